// File: rtl/queue_instruction_param_pkg.sv
// Shared defaults for the fetch/decode instruction queue.
//   DEF_WORD  : instruction width in bits
//   DEF_ADDR  : program-counter width in bits
//   DEF_DEPTH : queue depth in entries (power of two, >= 2)
//   DEF_SKID  : entries held in reserve once stall_o asserts
package queue_instruction_param_pkg;

    localparam int DEF_WORD  = 32;
    localparam int DEF_ADDR  = 32;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_SKID  = 1;

endpackage

// File: rtl/queue_instruction_param_fifo_ptr_ram.sv
// Circular FIFO storage with read/write pointers and an occupancy count.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   wr_en, wr_data    : write wr_data at wr_ptr, advance wr_ptr
//   rd_en, rd_data    : rd_data is the head entry (combinational); rd_en advances rd_ptr
//   clr               : return pointers and count to zero (overrides wr_en/rd_en)
//   count, full, empty: occupancy status from the registered count
// Callers must not assert wr_en when full or rd_en when empty.
module queue_instruction_param_fifo_ptr_ram
    import queue_instruction_param_pkg::*;
#(
    parameter int W     = DEF_WORD + DEF_ADDR,
    parameter int DEPTH = DEF_DEPTH,
    parameter int W_CNT = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    input  logic             clr,
    output logic [W_CNT-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is not reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/queue_instruction_param.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of (inst, pc).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   v_i, inst_i, pc_i    : upstream word from fetch
//   stall_o              : asks fetch to stop issuing (SKID entries early)
//   v_o, inst_o, pc_o    : head entry toward decode
//   stall_i              : decode cannot take the head this cycle
//   branch_i             : taken branch, flushes the queue
//   count_o              : current occupancy
//   ovf_o                : sticky, a valid word was dropped while full
module queue_instruction_param
    import queue_instruction_param_pkg::*;
#(
    parameter int WORD  = DEF_WORD,
    parameter int ADDR  = DEF_ADDR,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SKID  = DEF_SKID,
    parameter int W_CNT = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    output logic             stall_o,
    input  logic [WORD-1:0]  inst_i,
    input  logic [ADDR-1:0]  pc_i,
    output logic             v_o,
    input  logic             stall_i,
    output logic [WORD-1:0]  inst_o,
    output logic [ADDR-1:0]  pc_o,
    input  logic             branch_i,
    output logic [W_CNT-1:0] count_o,
    output logic             ovf_o
);

    localparam int ENTRY = WORD + ADDR;
    localparam logic [W_CNT-1:0] STALL_TH = W_CNT'(DEPTH - SKID);

    logic             wr_en;
    logic             rd_en;
    logic             full;
    logic             empty;
    logic [W_CNT-1:0] count;
    logic [ENTRY-1:0] rd_data;
    logic             ovf;

    // Acceptance uses the true full condition rather than stall_o so that
    // words already in flight when stall_o rises still land in the skid space.
    // A flush discards both sides of the handshake for this cycle.
    assign wr_en = v_i && !full && !branch_i;
    assign rd_en = !empty && !stall_i && !branch_i;

    queue_instruction_param_fifo_ptr_ram #(
        .W     (ENTRY),
        .DEPTH (DEPTH),
        .W_CNT (W_CNT)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data ({inst_i, pc_i}),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .clr     (branch_i),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Overflow survives flushes; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (v_i && full && !branch_i) begin
            ovf <= 1'b1;
        end
    end

    assign v_o     = !empty;
    assign inst_o  = rd_data[ENTRY-1:ADDR];
    assign pc_o    = rd_data[ADDR-1:0];
    assign stall_o = (count >= STALL_TH);
    assign count_o = count;
    assign ovf_o   = ovf;

endmodule

// File: tb/tb_queue_instruction_param.sv
module tb_queue_instruction_param;

    localparam int WORD  = 32;
    localparam int ADDR  = 32;
    localparam int DEPTH = 8;
    localparam int SKID  = 1;
    localparam int W_CNT = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             v_i;
    logic             stall_o;
    logic [WORD-1:0]  inst_i;
    logic [ADDR-1:0]  pc_i;
    logic             v_o;
    logic             stall_i;
    logic [WORD-1:0]  inst_o;
    logic [ADDR-1:0]  pc_o;
    logic             branch_i;
    logic [W_CNT-1:0] count_o;
    logic             ovf_o;

    int total = 0;
    int bad   = 0;

    queue_instruction_param #(
        .WORD  (WORD),
        .ADDR  (ADDR),
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .v_i      (v_i),
        .stall_o  (stall_o),
        .inst_i   (inst_i),
        .pc_i     (pc_i),
        .v_o      (v_o),
        .stall_i  (stall_i),
        .inst_o   (inst_o),
        .pc_o     (pc_o),
        .branch_i (branch_i),
        .count_o  (count_o),
        .ovf_o    (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        v_i    = 1'b1;
        inst_i = inst;
        pc_i   = pc;
        tick();
        v_i    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        v_i      = 1'b0;
        inst_i   = '0;
        pc_i     = '0;
        stall_i  = 1'b0;
        branch_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_v",     64'(v_o),     64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ovf",   64'(ovf_o),   64'd0);

        // fill with decode stalled; stall_o rises at count 7, 8th still accepted
        stall_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(32'h100 + k, 32'(4 * k));
            chk("fill_count", 64'(count_o), 64'(k + 1));
            chk("fill_stall", 64'(stall_o), 64'((k + 1) >= 7));
            chk("fill_head",  64'(inst_o),  64'h100);
        end
        chk("fill_ovf", 64'(ovf_o), 64'd0);

        // overflow from full
        push(32'hDEAD, 32'hFFFC);
        chk("ovf_count", 64'(count_o), 64'd8);
        chk("ovf_flag",  64'(ovf_o),   64'd1);

        // drain in order, ovf sticky
        stall_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("drain_v",    64'(v_o),    64'd1);
            chk("drain_inst", 64'(inst_o), 64'(32'h100 + k));
            chk("drain_pc",   64'(pc_o),   64'(4 * k));
            tick();
        end
        chk("drain_empty", 64'(v_o),     64'd0);
        chk("drain_count", 64'(count_o), 64'd0);
        chk("drain_ovf",   64'(ovf_o),   64'd1);

        // streaming across pointer wrap: one push and one pop per cycle
        for (int k = 0; k < 20; k++) begin
            v_i    = 1'b1;
            inst_i = 32'h200 + k;
            pc_i   = 32'h1000 + 4 * k;
            tick();
            chk("strm_v",     64'(v_o),     64'd1);
            chk("strm_count", 64'(count_o), 64'd1);
            chk("strm_inst",  64'(inst_o),  64'(32'h200 + k));
            chk("strm_pc",    64'(pc_o),    64'(32'h1000 + 4 * k));
        end
        v_i = 1'b0;
        tick();
        chk("strm_end", 64'(count_o), 64'd0);

        // branch flush discards queued words and the same-cycle push
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) push(32'h300 + k, 32'h300 + 4 * k);
        chk("pre_flush_count", 64'(count_o), 64'd5);
        branch_i = 1'b1;
        push(32'hBEEF, 32'hBEE0);
        branch_i = 1'b0;
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_v",     64'(v_o),     64'd0);
        chk("flush_ovf",   64'(ovf_o),   64'd1);
        push(32'h400, 32'h40);
        chk("post_flush_v",    64'(v_o),     64'd1);
        chk("post_flush_inst", 64'(inst_o),  64'h400);
        chk("post_flush_pc",   64'(pc_o),    64'h40);
        chk("post_flush_cnt",  64'(count_o), 64'd1);
        stall_i = 1'b0;
        tick();
        chk("post_flush_pop", 64'(count_o), 64'd0);

        // mid-run reset with traffic present
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) push(32'h450 + k, 32'(k));
        chk("pre_rst_count", 64'(count_o), 64'd3);
        reset    = 1'b1;
        branch_i = 1'b1;
        push(32'h4FF, 32'h4FF);
        reset    = 1'b0;
        branch_i = 1'b0;
        chk("mrst_count", 64'(count_o), 64'd0);
        chk("mrst_v",     64'(v_o),     64'd0);
        chk("mrst_ovf",   64'(ovf_o),   64'd0);
        chk("mrst_stall", 64'(stall_o), 64'd0);

        // full with simultaneous pop: push refused, ovf set
        for (int k = 0; k < 8; k++) push(32'h500 + k, 32'h5000 + k);
        chk("full2_count", 64'(count_o), 64'd8);
        chk("full2_ovf",   64'(ovf_o),   64'd0);
        stall_i = 1'b0;
        push(32'h5FF, 32'h5FFF);
        chk("fpp_count", 64'(count_o), 64'd7);
        chk("fpp_ovf",   64'(ovf_o),   64'd1);
        for (int k = 1; k < 8; k++) begin
            chk("fpp_inst", 64'(inst_o), 64'(32'h500 + k));
            chk("fpp_pc",   64'(pc_o),   64'(32'h5000 + k));
            tick();
        end
        chk("fpp_empty", 64'(v_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
